// File: rtl/regfile_sequencer.sv
// regfile_sequencer: accepts one register-file command at a time and
// expands it into a sequence of single-cycle register-file strobes.
// Optional build macro: REGFILE_SEQUENCER_ADDR_CHECK_EN rejects
// GET/PUT/MOVE commands that touch the reserved addresses 0xC-0xF.

package register_file_pkg;

  // Reserved register codes used by the LDDA/LDIA address-load sequences.
  localparam logic [3:0] REG_DBAR = 4'hC;
  localparam logic [3:0] REG_DOFF = 4'hD;
  localparam logic [3:0] REG_IBAR = 4'hE;
  localparam logic [3:0] REG_IOFF = 4'hF;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_GET   = 3'd1,
    OP_PUT   = 3'd2,
    OP_LDI   = 3'd3,
    OP_FLAGS = 3'd4,
    OP_MOVE  = 3'd5,
    OP_LDDA  = 3'd6,
    OP_LDIA  = 3'd7
  } op_e;

endpackage

module regfile_sequencer
  import register_file_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_op,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2*DATA_W-1:0]       cmd_imm,
  output logic                      done,
  output logic                      cmd_err,
  output logic [DATA_W-1:0]         acc_in,
  output logic                      acc_write_enable,
  output logic                      read_get_to_acc,
  output logic                      write_put_acc,
  output logic                      status_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic                      zero_flag,
  output logic                      positive_flag,
  output logic                      carry_flag,
  output logic                      overflow_flag
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_STEP = 1'b1
  } state_e;

  // Everything the output registers need for one cycle.
  typedef struct packed {
    logic                      acc_we;
    logic                      get;
    logic                      put;
    logic                      st_we;
    logic                      done;
    logic                      err;
    logic [DATA_W-1:0]         acc_val;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [3:0]                flags;
  } step_t;

  state_e                    state_q, state_d;
  logic [1:0]                step_q, step_d;
  logic [1:0]                last_q;
  op_e                       op_q;
  logic [REG_ADDR_WIDTH-1:0] addr_q;
  logic [2*DATA_W-1:0]       imm_q;
  logic                      accept;
  logic                      accept_err;
  step_t                     out_d;

  // Index of the final step for each opcode.
  function automatic logic [1:0] last_step(op_e op);
    case (op)
      OP_MOVE:          return 2'd1;
      OP_LDDA, OP_LDIA: return 2'd3;
      default:          return 2'd0;
    endcase
  endfunction

  // Strobes and data for one step of a command.
  function automatic step_t decode(op_e op, logic [REG_ADDR_WIDTH-1:0] addr,
                                   logic [2*DATA_W-1:0] imm, logic [1:0] step,
                                   logic err);
    step_t s;
    s = '0;
    if (err) begin
      s.err  = 1'b1;
      s.done = 1'b1;
      return s;
    end
    case (op)
      OP_GET: begin
        s.get  = 1'b1;
        s.addr = addr;
      end
      OP_PUT: begin
        s.put  = 1'b1;
        s.addr = addr;
      end
      OP_LDI: begin
        s.acc_we  = 1'b1;
        s.acc_val = imm[DATA_W-1:0];
      end
      OP_FLAGS: begin
        s.st_we = 1'b1;
        s.flags = imm[3:0];
      end
      OP_MOVE: begin
        // Source goes through the accumulator, so the accumulator is clobbered.
        if (step == 2'd0) begin
          s.get  = 1'b1;
          s.addr = addr;
        end else begin
          s.put  = 1'b1;
          s.addr = REG_ADDR_WIDTH'(imm[3:0]);
        end
      end
      OP_LDDA, OP_LDIA: begin
        case (step)
          2'd0: begin
            s.acc_we  = 1'b1;
            s.acc_val = imm[2*DATA_W-1:DATA_W];
          end
          2'd1: begin
            s.put  = 1'b1;
            s.addr = REG_ADDR_WIDTH'((op == OP_LDDA) ? REG_DBAR : REG_IBAR);
          end
          2'd2: begin
            s.acc_we  = 1'b1;
            s.acc_val = imm[DATA_W-1:0];
          end
          default: begin
            s.put  = 1'b1;
            s.addr = REG_ADDR_WIDTH'((op == OP_LDDA) ? REG_DOFF : REG_IOFF);
          end
        endcase
      end
      default: ;
    endcase
    s.done = (step == last_step(op));
    return s;
  endfunction

`ifdef REGFILE_SEQUENCER_ADDR_CHECK_EN
  function automatic logic addr_reserved(logic [REG_ADDR_WIDTH-1:0] a);
    int unsigned ua;
    ua = 32'(a);
    return (ua >= 32'd12) && (ua <= 32'd15);
  endfunction

  // Reject commands whose source or destination lands in the reserved range.
  always_comb begin
    accept_err = 1'b0;
    if ((op_e'(cmd_op) == OP_GET) || (op_e'(cmd_op) == OP_PUT) ||
        (op_e'(cmd_op) == OP_MOVE))
      accept_err = addr_reserved(cmd_addr);
    if ((op_e'(cmd_op) == OP_MOVE) &&
        addr_reserved(REG_ADDR_WIDTH'(cmd_imm[3:0])))
      accept_err = 1'b1;
  end
`else
  assign accept_err = 1'b0;
`endif

  // Next state and the output values for the coming cycle.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    out_d   = '0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = S_STEP;
          step_d  = 2'd0;
          out_d   = decode(op_e'(cmd_op), cmd_addr, cmd_imm, 2'd0, accept_err);
        end
      end
      default: begin
        if (step_q == last_q) begin
          state_d = S_IDLE;
        end else begin
          step_d = step_q + 2'd1;
          out_d  = decode(op_q, addr_q, imm_q, step_q + 2'd1, 1'b0);
        end
      end
    endcase
  end

  // State and step counter; reset drops any command in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Operand capture at acceptance.
  // NOTE: pure data registers, only read while in STEP after being loaded,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op_e'(cmd_op);
      addr_q <= cmd_addr;
      imm_q  <= cmd_imm;
      last_q <= accept_err ? 2'd0 : last_step(op_e'(cmd_op));
    end
  end

  // Registered outputs; data outputs only move when their strobe fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready           <= 1'b1;
      done                <= 1'b0;
      cmd_err             <= 1'b0;
      acc_write_enable    <= 1'b0;
      read_get_to_acc     <= 1'b0;
      write_put_acc       <= 1'b0;
      status_write_enable <= 1'b0;
      acc_in              <= '0;
      reg_addr            <= '0;
      zero_flag           <= 1'b0;
      positive_flag       <= 1'b0;
      carry_flag          <= 1'b0;
      overflow_flag       <= 1'b0;
    end else begin
      cmd_ready           <= (state_d == S_IDLE);
      done                <= out_d.done;
      cmd_err             <= out_d.err;
      acc_write_enable    <= out_d.acc_we;
      read_get_to_acc     <= out_d.get;
      write_put_acc       <= out_d.put;
      status_write_enable <= out_d.st_we;
      if (out_d.acc_we) acc_in <= out_d.acc_val;
      if (out_d.get || out_d.put) reg_addr <= out_d.addr;
      if (out_d.st_we)
        {zero_flag, positive_flag, carry_flag, overflow_flag} <= out_d.flags;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed self-checking bench for regfile_sequencer (default parameters).
// Reserved register codes expected: DBAR=C, DOFF=D, IBAR=E, IOFF=F.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_imm;
  logic        done, cmd_err;
  logic [7:0]  acc_in;
  logic        acc_write_enable, read_get_to_acc, write_put_acc, status_write_enable;
  logic [3:0]  reg_addr;
  logic        zero_flag, positive_flag, carry_flag, overflow_flag;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sequencer #(.DATA_W(8), .REG_ADDR_WIDTH(4)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_op              (cmd_op),
    .cmd_addr            (cmd_addr),
    .cmd_imm             (cmd_imm),
    .done                (done),
    .cmd_err             (cmd_err),
    .acc_in              (acc_in),
    .acc_write_enable    (acc_write_enable),
    .read_get_to_acc     (read_get_to_acc),
    .write_put_acc       (write_put_acc),
    .status_write_enable (status_write_enable),
    .reg_addr            (reg_addr),
    .zero_flag           (zero_flag),
    .positive_flag       (positive_flag),
    .carry_flag          (carry_flag),
    .overflow_flag       (overflow_flag)
  );

  always #5 clk = ~clk;

  // Strobe order {acc_we, get, put, status_we}; flag order {z, p, c, o}.
  logic [3:0] strb, flg;
  assign strb = {acc_write_enable, read_get_to_acc, write_put_acc, status_write_enable};
  assign flg  = {zero_flag, positive_flag, carry_flag, overflow_flag};

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  addr;
    logic [15:0] imm;
    logic [3:0]  strb;
    logic [7:0]  acc;
    logic [3:0]  ra;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Full output snapshot for one cycle.
  task automatic expect_out(input string tag, input logic [3:0] e_strb, input logic e_done,
                            input logic e_err, input logic e_ready, input logic [7:0] e_acc,
                            input logic [3:0] e_ra, input logic [3:0] e_fl);
    check({tag, ".strb"},  32'(strb),      32'(e_strb));
    check({tag, ".done"},  32'(done),      32'(e_done));
    check({tag, ".err"},   32'(cmd_err),   32'(e_err));
    check({tag, ".ready"}, 32'(cmd_ready), 32'(e_ready));
    check({tag, ".acc"},   32'(acc_in),    32'(e_acc));
    check({tag, ".addr"},  32'(reg_addr),  32'(e_ra));
    check({tag, ".flags"}, 32'(flg),       32'(e_fl));
  endtask

  // Offer a command for one accepting edge, then scramble the inputs so any
  // late sampling of the command bus shows up. Returns #1 after the accept edge.
  task automatic send(input logic [2:0] op, input logic [3:0] addr, input logic [15:0] imm);
    @(negedge clk);
    check("send.ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_imm   = imm;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_addr  = 4'($urandom_range(0, 15));
    cmd_imm   = 16'($urandom);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{3'd3, 4'h0, 16'h00AA, 4'b1000, 8'hAA, 4'h0, 4'h0}; // LDI AA
    vecs[1] = '{3'd1, 4'h5, 16'hFFFF, 4'b0100, 8'hAA, 4'h5, 4'h0}; // GET 5
    vecs[2] = '{3'd2, 4'h9, 16'h0000, 4'b0010, 8'hAA, 4'h9, 4'h0}; // PUT 9
    vecs[3] = '{3'd4, 4'h3, 16'h000A, 4'b0001, 8'hAA, 4'h9, 4'hA}; // FLAGS z,c
    vecs[4] = '{3'd0, 4'h7, 16'h1234, 4'b0000, 8'hAA, 4'h9, 4'hA}; // NOP holds
    vecs[5] = '{3'd3, 4'h0, 16'h1F55, 4'b1000, 8'h55, 4'h9, 4'hA}; // LDI low byte
    vecs[6] = '{3'd4, 4'h0, 16'hFFF5, 4'b0001, 8'h55, 4'h9, 4'h5}; // FLAGS p,o
    vecs[7] = '{3'd1, 4'hB, 16'h0000, 4'b0100, 8'h55, 4'hB, 4'h5}; // GET B

    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_addr  = 4'h0;
    cmd_imm   = 16'h0;
    reset_n   = 1'b0;
    #12;
    expect_out("reset", 4'b0000, 1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single-step commands: one strobe cycle with done, then one idle cycle.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].op, vecs[i].addr, vecs[i].imm);
      expect_out($sformatf("vec%0d.step", i), vecs[i].strb, 1'b1, 1'b0, 1'b0,
                 vecs[i].acc, vecs[i].ra, vecs[i].fl);
      next_cycle();
      expect_out($sformatf("vec%0d.idle", i), 4'b0000, 1'b0, 1'b0, 1'b1,
                 vecs[i].acc, vecs[i].ra, vecs[i].fl);
    end

    // MOVE 1 -> 3: GET then PUT, done only on the PUT.
    send(3'd5, 4'h1, 16'h0003);
    expect_out("move.s0", 4'b0100, 1'b0, 1'b0, 1'b0, 8'h55, 4'h1, 4'h5);
    next_cycle();
    expect_out("move.s1", 4'b0010, 1'b1, 1'b0, 1'b0, 8'h55, 4'h3, 4'h5);
    next_cycle();
    expect_out("move.idle", 4'b0000, 1'b0, 1'b0, 1'b1, 8'h55, 4'h3, 4'h5);

    // LDDA 0x1234 and LDIA 0xBEEF: four steps each.
    send(3'd6, 4'h0, 16'h1234);
    expect_out("ldda.s0", 4'b1000, 1'b0, 1'b0, 1'b0, 8'h12, 4'h3, 4'h5);
    next_cycle();
    expect_out("ldda.s1", 4'b0010, 1'b0, 1'b0, 1'b0, 8'h12, 4'hC, 4'h5);
    next_cycle();
    expect_out("ldda.s2", 4'b1000, 1'b0, 1'b0, 1'b0, 8'h34, 4'hC, 4'h5);
    next_cycle();
    expect_out("ldda.s3", 4'b0010, 1'b1, 1'b0, 1'b0, 8'h34, 4'hD, 4'h5);
    next_cycle();
    expect_out("ldda.idle", 4'b0000, 1'b0, 1'b0, 1'b1, 8'h34, 4'hD, 4'h5);

    send(3'd7, 4'h0, 16'hBEEF);
    expect_out("ldia.s0", 4'b1000, 1'b0, 1'b0, 1'b0, 8'hBE, 4'hD, 4'h5);
    next_cycle();
    expect_out("ldia.s1", 4'b0010, 1'b0, 1'b0, 1'b0, 8'hBE, 4'hE, 4'h5);
    next_cycle();
    expect_out("ldia.s2", 4'b1000, 1'b0, 1'b0, 1'b0, 8'hEF, 4'hE, 4'h5);
    next_cycle();
    expect_out("ldia.s3", 4'b0010, 1'b1, 1'b0, 1'b0, 8'hEF, 4'hF, 4'h5);
    next_cycle();
    expect_out("ldia.idle", 4'b0000, 1'b0, 1'b0, 1'b1, 8'hEF, 4'hF, 4'h5);

    // Reserved address 0xC on PUT.
    send(3'd2, 4'hC, 16'h0000);
`ifdef REGFILE_SEQUENCER_ADDR_CHECK_EN
    expect_out("put_c.step", 4'b0000, 1'b1, 1'b1, 1'b0, 8'hEF, 4'hF, 4'h5);
`else
    expect_out("put_c.step", 4'b0010, 1'b1, 1'b0, 1'b0, 8'hEF, 4'hC, 4'h5);
`endif
    next_cycle();
    check("put_c.idle_err", 32'(cmd_err), 32'd0);
    check("put_c.idle_ready", 32'(cmd_ready), 32'd1);

    // Reset asserted mid-cycle during LDIA step1: in-flight command dropped.
    send(3'd7, 4'h0, 16'h5678);
    check("rst.s0_strb", 32'(strb), 32'b1000);
    next_cycle();
    check("rst.s1_strb", 32'(strb), 32'b0010);
    #2;
    reset_n = 1'b0;
    #1;
    expect_out("rst.async", 4'b0000, 1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    expect_out("rst.after", 4'b0000, 1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 4'h0);
    next_cycle();
    check("rst.no_late_done", 32'(done), 32'd0);

    // Sequencer is usable again after the dropped command.
    send(3'd3, 4'h0, 16'h00C3);
    expect_out("post_rst.ldi", 4'b1000, 1'b1, 1'b0, 1'b0, 8'hC3, 4'h0, 4'h0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
